tmr_fault_monitor: RTL and testbench
====================================

# tmr_fault_monitor

Sequential monitor that sits directly downstream of the 3-input agreement classifier. Each accepted sample is a 2-bit code from the classifier: which of the three redundant lanes disagrees with the other two, or "all agree". The block tracks per-lane consecutive-disagreement streaks and declares a lane faulted when its streak reaches a threshold. It reports each new fault over a valid/ready channel and keeps a saturating total-error count and a health state.

## Interface
- THRESH, default 4: consecutive odd-one-out samples on one lane that declare it faulted; legal range 1..15.
- CNT_W, default 8: width of the total-error counter.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_code is valid this cycle; there is no backpressure, so every valid cycle is accepted.
- in_code  input  2  classifier code: 00 = lane 0 odd, 01 = lane 1 odd, 10 = lane 2 odd, 11 = all agree.
- clear  input  1  synchronous clear of streaks, faults, pending reports, error count and state.
- fault  output  3  sticky per-lane fault flags.
- err_count  output  CNT_W  saturating count of accepted disagreeing samples.
- state  output  2  00 HEALTHY, 01 SUSPECT, 10 FAULTED, 11 DEGRADED.
- rpt_valid  output  1  a fault report is presented.
- rpt_lane  output  2  lane index of the presented report (0..2).
- rpt_ready  input  1  consumer accepts the report.

## Operation
- Accepted sample with code 11:
  - clear all three streak counters to 0.
  - err_count unchanged.
- Accepted sample with code k (0..2):
  - streak[k] increments, saturating at THRESH.
  - the other two streaks clear to 0.
  - err_count increments, saturating at all-ones.
- Fault declaration:
  - when streak[k] becomes equal to THRESH and fault[k]=0, set fault[k] and set pending[k].
  - a lane that is already faulted never re-reports; its streak still counts and saturates.
- Report channel:
  - when the output register is empty and pending is nonzero, load the lowest-indexed pending lane into rpt_lane, clear that pending bit, and assert rpt_valid.
  - rpt_valid and rpt_lane hold stable until the cycle where rpt_valid && rpt_ready.
  - after acceptance, the next pending lane, if any, is presented on the following cycle. Back-to-back reports therefore have one idle cycle between them.
- State, registered and computed from the next-cycle values of fault and the streaks:
  - DEGRADED: two or more fault bits set.
  - FAULTED: exactly one fault bit set.
  - SUSPECT: no faults and some streak > 0.
  - HEALTHY: otherwise.
- clear:
  - takes priority over an accepted sample in the same cycle; that sample is dropped.
  - zeroes streaks, fault, pending, err_count and rpt_valid, and sets state to HEALTHY.
  - an in-flight report is discarded.
- in_valid=0: streaks, counters and state hold. The report channel still operates.

## Timing
- Reset (asynchronous assert): all outputs are 0, i.e. fault=000, err_count=0, state=HEALTHY, rpt_valid=0, rpt_lane=00; all internal streak and pending bits are 0.
- Sample to fault/err_count/state update: 1 cycle. All outputs are registered.
- Fault-setting sample edge to rpt_valid high: 2 cycles, with pending registered and then loaded into the output register.
- Simultaneous events:
  - a report handshake and a new fault on another lane in the same cycle both take effect; the new lane waits in pending.
  - a lower-index lane becoming pending while a higher-index lane is presented does not preempt it.
- Reset mid-operation: reports and counts are lost. There is no replay after reset is released.

## Structure
- Shared package tmr_pkg:
  - code constants CODE_ODD0=2'b00, CODE_ODD1=2'b01, CODE_ODD2=2'b10, CODE_AGREE=2'b11.
  - state enum HEALTHY/SUSPECT/FAULTED/DEGRADED.
  - lane-index type.
- Sub-module tmr_streak_counter, instantiated three times, with ports clk, rst, clear, inc, zero, and outputs streak and hit (streak==THRESH).
- Top level holds fault/pending registers, the report output register, err_count and the state register.

## Test plan
- Reset, then 10 samples of code 11 -> fault=000, err_count=0, state=HEALTHY, rpt_valid=0 throughout.
- Codes 01,01,01,01 with rpt_ready=1 (THRESH=4):
  - state=SUSPECT after the first sample.
  - fault=010 and state=FAULTED one cycle after the fourth sample.
  - rpt_valid high for one cycle with rpt_lane=01.
  - err_count=4.
- Codes 00,00,00,11,00,00,00 -> no fault; streak restart confirmed; state returns to HEALTHY after the code-11 sample; err_count=6.
- rpt_ready=0, then 4×10 followed by 4×00 -> fault=101, state=DEGRADED, rpt_lane=10 held stable. Then raise rpt_ready -> lane 10 accepted, one idle cycle, then lane 00 presented.
- Drive 300 samples of code 00 with CNT_W=8 -> err_count saturates at 255 and lane 0 reports exactly once.
- clear asserted with in_valid=1 and code 00 on the same cycle while a report is pending -> next cycle all outputs are 0 and state=HEALTHY, and the sample is not counted.

Source files
------------

// File: rtl/tmr_pkg.sv
// tmr_pkg: definitions shared by the TMR fault monitor.
// It holds the classifier code constants, the health-state encoding, the lane index type,
// the streak counter width and a small popcount helper.
package tmr_pkg;

    localparam logic [1:0] CODE_ODD0  = 2'b00;
    localparam logic [1:0] CODE_ODD1  = 2'b01;
    localparam logic [1:0] CODE_ODD2  = 2'b10;
    localparam logic [1:0] CODE_AGREE = 2'b11;

    localparam int NUM_LANES = 3;

    // Wide enough for the largest legal threshold (15).
    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        HEALTHY  = 2'b00,
        SUSPECT  = 2'b01,
        FAULTED  = 2'b10,
        DEGRADED = 2'b11
    } health_e;

    typedef logic [1:0] lane_t;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/tmr_fault_monitor_if.sv
// tmr_fault_monitor_if: groups the sample input channel and the fault-report channel.
//   in_valid / in_code : classifier samples; there is no backpressure.
//   rpt_valid / rpt_lane / rpt_ready : valid/ready fault-report channel.
// Modports:
//   master : the environment (classifier plus report consumer).
//   slave  : the monitor.
interface tmr_fault_monitor_if;
    import tmr_pkg::*;

    logic  in_valid;
    logic  [1:0] in_code;
    logic  rpt_valid;
    lane_t rpt_lane;
    logic  rpt_ready;

    modport master (
        output in_valid, in_code, rpt_ready,
        input  rpt_valid, rpt_lane
    );

    modport slave (
        input  in_valid, in_code, rpt_ready,
        output rpt_valid, rpt_lane
    );
endinterface

// File: rtl/tmr_streak_counter.sv
// tmr_streak_counter: counts consecutive odd-one-out samples for one lane.
// The count saturates at THRESH.
// Ports:
//   clk, rst : clock and asynchronous active-high reset.
//   clear    : synchronous zero; takes priority over everything else.
//   inc      : this lane is the odd one out on an accepted sample.
//   zero     : an accepted sample that does not implicate this lane.
//   streak   : current streak value.
//   hit      : the streak is at THRESH after this edge because of an increment.
//              Using the post-edge value lets the fault flag rise on the same edge
//              as the sample that completes the streak.
module tmr_streak_counter
    import tmr_pkg::*;
#(
    parameter int THRESH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                inc,
    input  logic                zero,
    output logic [STREAK_W-1:0] streak,
    output logic                hit
);
    localparam logic [STREAK_W-1:0] THRESH_V = STREAK_W'(THRESH);

    logic [STREAK_W-1:0] streak_q, streak_d;

    always_comb begin
        streak_d = streak_q;
        if (clear || zero) begin
            streak_d = '0;
        end else if (inc && streak_q != THRESH_V) begin
            streak_d = streak_q + 1'b1;
        end
        hit = inc && !clear && (streak_d == THRESH_V);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign streak = streak_q;
endmodule

// File: rtl/tmr_fault_monitor.sv
// tmr_fault_monitor: tracks per-lane disagreement streaks from a TMR agreement classifier.
// It latches sticky lane faults, reports each new fault once over a valid/ready channel,
// and keeps a saturating error count and a health state.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset.
//   bus       : sample channel and report channel (slave modport).
//   clear     : synchronous clear of all monitor state; drops a same-cycle sample.
//   fault     : sticky per-lane fault flags.
//   err_count : saturating count of accepted disagreeing samples.
//   state     : HEALTHY / SUSPECT / FAULTED / DEGRADED.
module tmr_fault_monitor
    import tmr_pkg::*;
#(
    parameter int THRESH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    tmr_fault_monitor_if.slave    bus,
    input  logic                  clear,
    output logic [NUM_LANES-1:0]  fault,
    output logic [CNT_W-1:0]      err_count,
    output health_e               state
);
    logic                 accept;
    logic [NUM_LANES-1:0] inc, zero, hit;
    logic [STREAK_W-1:0]  streak [NUM_LANES];
    logic                 streak_nz_q;

    logic [NUM_LANES-1:0] fault_q, fault_d;
    logic [NUM_LANES-1:0] pending_q, pending_d;
    logic                 rpt_valid_q, rpt_valid_d;
    lane_t                rpt_lane_q, rpt_lane_d;
    logic [CNT_W-1:0]     err_count_q, err_count_d;
    health_e              state_q, state_d;

    logic [NUM_LANES-1:0] new_fault;
    logic                 load, handshake, streak_nz_d;
    lane_t                load_lane;
    logic [NUM_LANES-1:0] load_mask;

    assign accept = bus.in_valid && !clear;

    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            inc[k]  = accept && (bus.in_code == lane_t'(k));
            zero[k] = accept && (bus.in_code != lane_t'(k));
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        tmr_streak_counter #(.THRESH(THRESH)) u_streak (
            .clk    (clk),
            .rst    (rst),
            .clear  (clear),
            .inc    (inc[g]),
            .zero   (zero[g]),
            .streak (streak[g]),
            .hit    (hit[g])
        );
    end

    assign streak_nz_q = (streak[0] != '0) || (streak[1] != '0) || (streak[2] != '0);

    always_comb begin
        // A lane already faulted keeps saturating but never reports again.
        new_fault = hit & ~fault_q;
        handshake = rpt_valid_q && bus.rpt_ready;
        // The output register refills only from empty, which leaves one idle cycle
        // between back-to-back reports and prevents a newly pending lane from preempting.
        load      = !rpt_valid_q && (pending_q != '0);
        if (pending_q[0]) begin
            load_lane = 2'd0;
            load_mask = 3'b001;
        end else if (pending_q[1]) begin
            load_lane = 2'd1;
            load_mask = 3'b010;
        end else begin
            load_lane = 2'd2;
            load_mask = 3'b100;
        end

        fault_d     = fault_q;
        pending_d   = pending_q;
        rpt_valid_d = rpt_valid_q;
        rpt_lane_d  = rpt_lane_q;
        err_count_d = err_count_q;
        state_d     = state_q;
        // Any streak is nonzero next cycle exactly when a disagreeing sample lands;
        // an agreeing sample zeroes them all, and no sample holds them.
        streak_nz_d = accept ? (bus.in_code != CODE_AGREE) : streak_nz_q;

        if (clear) begin
            fault_d     = '0;
            pending_d   = '0;
            rpt_valid_d = 1'b0;
            rpt_lane_d  = '0;
            err_count_d = '0;
            state_d     = HEALTHY;
        end else begin
            fault_d   = fault_q | new_fault;
            pending_d = (pending_q & ~(load ? load_mask : 3'b000)) | new_fault;
            if (load) begin
                rpt_valid_d = 1'b1;
                rpt_lane_d  = load_lane;
            end else if (handshake) begin
                rpt_valid_d = 1'b0;
            end
            if (accept && bus.in_code != CODE_AGREE && err_count_q != {CNT_W{1'b1}}) begin
                err_count_d = err_count_q + 1'b1;
            end
            if (popcount3(fault_d) >= 2'd2) begin
                state_d = DEGRADED;
            end else if (popcount3(fault_d) == 2'd1) begin
                state_d = FAULTED;
            end else if (streak_nz_d) begin
                state_d = SUSPECT;
            end else begin
                state_d = HEALTHY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q     <= '0;
            pending_q   <= '0;
            rpt_valid_q <= 1'b0;
            rpt_lane_q  <= '0;
            err_count_q <= '0;
            state_q     <= HEALTHY;
        end else begin
            fault_q     <= fault_d;
            pending_q   <= pending_d;
            rpt_valid_q <= rpt_valid_d;
            rpt_lane_q  <= rpt_lane_d;
            err_count_q <= err_count_d;
            state_q     <= state_d;
        end
    end

    assign fault         = fault_q;
    assign err_count     = err_count_q;
    assign state         = state_q;
    assign bus.rpt_valid = rpt_valid_q;
    assign bus.rpt_lane  = rpt_lane_q;
endmodule

// File: tb/tb_tmr_fault_monitor.sv
module tb_tmr_fault_monitor;
    localparam int THRESH  = 4;
    localparam int CNT_W   = 8;
    localparam int ERR_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic [2:0] fault;
    logic [CNT_W-1:0] err_count;
    logic [1:0] state;

    tmr_fault_monitor_if bus();

    tmr_fault_monitor #(.THRESH(THRESH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .clear     (clear),
        .fault     (fault),
        .err_count (err_count),
        .state     (state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int dut_rpt_cnt [3] = '{0, 0, 0};

    // Behavioural model, updated once per active clock edge.
    int m_streak [3];
    bit m_fault  [3];
    bit m_pend   [3];
    bit m_rv;
    int m_lane;
    int m_err;
    int m_state;

    function automatic void m_reset();
        for (int j = 0; j < 3; j++) begin
            m_streak[j] = 0;
            m_fault[j]  = 0;
            m_pend[j]   = 0;
        end
        m_rv = 0; m_lane = 0; m_err = 0; m_state = 0;
    endfunction

    function automatic void m_step(input bit v, input int code, input bit clr, input bit rdy);
        bit newp [3];
        int nf, nz;
        if (clr) begin
            m_reset();
            return;
        end
        for (int j = 0; j < 3; j++) newp[j] = 0;
        if (v) begin
            for (int j = 0; j < 3; j++)
                m_streak[j] = (j == code) ? ((m_streak[j] < THRESH) ? m_streak[j] + 1 : THRESH) : 0;
            if (code != 3) begin
                m_err = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
                if (m_streak[code] == THRESH && !m_fault[code]) begin
                    m_fault[code] = 1;
                    newp[code] = 1;
                end
            end
        end
        if (!m_rv) begin
            for (int j = 0; j < 3; j++) begin
                if (m_pend[j]) begin
                    m_pend[j] = 0;
                    m_rv = 1;
                    m_lane = j;
                    break;
                end
            end
        end else if (rdy) begin
            m_rv = 0;
        end
        for (int j = 0; j < 3; j++) m_pend[j] = m_pend[j] | newp[j];
        nf = 0; nz = 0;
        for (int j = 0; j < 3; j++) begin
            nf += m_fault[j] ? 1 : 0;
            nz += (m_streak[j] > 0) ? 1 : 0;
        end
        m_state = (nf >= 2) ? 3 : (nf == 1) ? 2 : (nz > 0) ? 1 : 0;
    endfunction

    function automatic void chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
        end
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("fault", int'(fault), int'({m_fault[2], m_fault[1], m_fault[0]}));
        chk("err_count", int'(err_count), m_err);
        chk("state", int'(state), m_state);
        chk("rpt_valid", int'(bus.rpt_valid), int'(m_rv));
        if (bus.rpt_valid) chk("rpt_lane", int'(bus.rpt_lane), m_lane);
        if (bus.rpt_valid && bus.rpt_ready && bus.rpt_lane < 3) dut_rpt_cnt[bus.rpt_lane]++;
    end

    task automatic cycle(input bit v, input int code, input bit clr, input bit rdy);
        bus.in_valid  = v;
        bus.in_code   = code[1:0];
        clear         = clr;
        bus.rpt_ready = rdy;
        @(posedge clk);
        m_step(v, code, clr, rdy);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int r0, r1;
        int lane, code;
        bus.in_valid = 0; bus.in_code = 0; bus.rpt_ready = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // All-agree samples keep everything idle.
        for (int i = 0; i < 10; i++) begin
            cycle(1, 3, 0, 0);
            chk("agree_fault", int'(fault), 0);
            chk("agree_err", int'(err_count), 0);
            chk("agree_state", int'(state), 0);
            chk("agree_rv", int'(bus.rpt_valid), 0);
        end

        // Lane 1 odd four times.
        r1 = dut_rpt_cnt[1];
        cycle(1, 1, 0, 1);
        chk("l1_suspect", int'(state), 1);
        repeat (3) cycle(1, 1, 0, 1);
        chk("l1_fault", int'(fault), 3'b010);
        chk("l1_state", int'(state), 2);
        chk("l1_err", int'(err_count), 4);
        cycle(0, 3, 0, 1);
        chk("l1_rv", int'(bus.rpt_valid), 1);
        chk("l1_lane", int'(bus.rpt_lane), 1);
        repeat (3) cycle(0, 3, 0, 1);
        chk("l1_once", dut_rpt_cnt[1] - r1, 1);

        // Streak restart on an agreeing sample.
        cycle(0, 3, 1, 1);
        repeat (3) cycle(1, 0, 0, 1);
        cycle(1, 3, 0, 1);
        chk("restart_state", int'(state), 0);
        repeat (3) cycle(1, 0, 0, 1);
        chk("restart_fault", int'(fault), 0);
        chk("restart_err", int'(err_count), 6);

        // Two faults with the consumer stalled.
        repeat (4) cycle(1, 2, 0, 0);
        repeat (4) cycle(1, 0, 0, 0);
        chk("deg_fault", int'(fault), 3'b101);
        chk("deg_state", int'(state), 3);
        chk("deg_rv", int'(bus.rpt_valid), 1);
        chk("deg_lane", int'(bus.rpt_lane), 2);
        repeat (2) cycle(0, 3, 0, 0);
        chk("deg_hold", int'(bus.rpt_lane), 2);
        cycle(0, 3, 0, 1);
        chk("deg_idle", int'(bus.rpt_valid), 0);
        cycle(0, 3, 0, 0);
        chk("deg_next_rv", int'(bus.rpt_valid), 1);
        chk("deg_next_lane", int'(bus.rpt_lane), 0);
        cycle(0, 3, 0, 1);

        // Error counter saturation and single report.
        cycle(0, 3, 1, 1);
        r0 = dut_rpt_cnt[0];
        repeat (300) cycle(1, 0, 0, 1);
        repeat (4) cycle(0, 3, 0, 1);
        chk("sat_err", int'(err_count), 255);
        chk("sat_once", dut_rpt_cnt[0] - r0, 1);

        // Clear with a same-cycle sample while a report is pending.
        cycle(0, 3, 1, 0);
        repeat (4) cycle(1, 1, 0, 0);
        cycle(1, 0, 1, 0);
        chk("clr_fault", int'(fault), 0);
        chk("clr_err", int'(err_count), 0);
        chk("clr_state", int'(state), 0);
        chk("clr_rv", int'(bus.rpt_valid), 0);
        chk("clr_lane", int'(bus.rpt_lane), 0);

        // Randomized traffic with occasional clears and one mid-run reset.
        lane = 0;
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) do_reset();
            if ($urandom_range(0, 9) < 3) lane = $urandom_range(0, 3);
            code = ($urandom_range(0, 9) < 8) ? lane : $urandom_range(0, 3);
            cycle($urandom_range(0, 9) < 8, code, $urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1);
        end
        repeat (4) cycle(0, 3, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
